// File: rtl/umstr_udp_hdr_insert_if.sv
// umstr_udp_hdr_insert_if
//   32-bit byte-enabled stream used on both sides of the UDP header inserter.
//   Signals: tdata (32, [31:24] first byte on wire), tvld, tlast,
//            tkeep (4, [3] qualifies [31:24]), trdy.
//   Modports: master drives tdata/tvld/tlast/tkeep and samples trdy;
//             slave is the mirror image.
//
// Handshake: a beat transfers on a rising clk edge where tvld && trdy.
// While tvld is high and trdy is low, the master holds tdata/tkeep/tlast
// and tvld stable. trdy may depend combinationally on tvld and on state;
// tvld never depends on trdy.
interface umstr_udp_hdr_insert_if;
  logic [31:0] tdata;
  logic        tvld;
  logic        tlast;
  logic [3:0]  tkeep;
  logic        trdy;

  modport master (output tdata, output tvld, output tlast, output tkeep, input trdy);
  modport slave  (input tdata, input tvld, input tlast, input tkeep, output trdy);
endinterface

// File: rtl/umstr_udp_hdr_insert.sv
// umstr_udp_hdr_insert
//   Prepends the 8-byte UDP header (ports, length, checksum) to a 32-bit
//   payload stream. The checksum covers the IPv4 pseudo-header, the UDP
//   header and the payload sum supplied by the upstream stage.
// Parameters:
//   CSUM_EN  1 = compute checksum, 0 = checksum field sent as 16'h0000
// Ports:
//   clk, reset_n          clock, asynchronous active-low reset
//   hdr_ip_dest_i/src_i   IPv4 addresses, stable for the whole packet
//   hdr_port_dest_i/src_i UDP ports
//   user_data_csum_i      folded ones-complement sum of the payload
//   user_data_len_i       payload length in bytes
//   user                  payload stream in (slave)
//   hdr_ip_dest_o/src_o   addresses latched at packet start
//   ip_payload_len_o      UDP length (payload length + 8)
//   udp                   UDP datagram stream out (master)
//   dbg_state             current FSM state encoding
module umstr_udp_hdr_insert #(
  parameter bit CSUM_EN = 1'b1
) (
  input  logic                          clk,
  input  logic                          reset_n,
  input  logic [31:0]                   hdr_ip_dest_i,
  input  logic [31:0]                   hdr_ip_src_i,
  input  logic [15:0]                   hdr_port_dest_i,
  input  logic [15:0]                   hdr_port_src_i,
  input  logic [15:0]                   user_data_csum_i,
  input  logic [15:0]                   user_data_len_i,
  umstr_udp_hdr_insert_if.slave         user,
  output logic [31:0]                   hdr_ip_dest_o,
  output logic [31:0]                   hdr_ip_src_o,
  output logic [15:0]                   ip_payload_len_o,
  umstr_udp_hdr_insert_if.master        udp,
  output logic [2:0]                    dbg_state
);

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    CSUM = 3'd1,
    HDR0 = 3'd2,
    HDR1 = 3'd3,
    DATA = 3'd4
  } state_t;

  state_t      state, state_n;
  logic [15:0] port_src_q, port_dst_q, data_csum_q, csum_q;
  logic [19:0] acc;
  logic [16:0] fold1;
  logic [15:0] fold2, csum_calc;
  logic        ld;

  // Next-cycle contents of the output register
  logic        o_we, o_vld, o_last;
  logic [31:0] o_data;
  logic [3:0]  o_keep;

  // Output register may take a new value when empty or being drained.
  assign ld        = !udp.tvld || udp.trdy;
  assign user.trdy = (state == DATA) && ld;
  assign dbg_state = state;

  // Checksum from the latched fields; only sampled while in CSUM.
  // Ten 16-bit terms fit in 20 bits, so two folds always suffice.
  always_comb begin
    acc = 20'(hdr_ip_src_o[31:16])  + 20'(hdr_ip_src_o[15:0])
        + 20'(hdr_ip_dest_o[31:16]) + 20'(hdr_ip_dest_o[15:0])
        + 20'h00011                 + 20'(ip_payload_len_o)
        + 20'(port_src_q)           + 20'(port_dst_q)
        + 20'(ip_payload_len_o)     + 20'(data_csum_q);
    fold1 = {1'b0, acc[15:0]} + {13'b0, acc[19:16]};
    fold2 = fold1[15:0] + {15'b0, fold1[16]};
    csum_calc = ~fold2;
    // A computed zero is sent as all-ones; zero on the wire means "none".
    if (csum_calc == 16'h0000) csum_calc = 16'hFFFF;
    if (!CSUM_EN) csum_calc = 16'h0000;
  end

  always_comb begin
    state_n = state;
    o_we    = ld;   // an idle or drained register clears its valid
    o_vld   = 1'b0;
    o_last  = 1'b0;
    o_data  = 32'h0;
    o_keep  = 4'h0;
    case (state)
      IDLE: if (user.tvld) state_n = CSUM;
      CSUM: state_n = HDR0;
      HDR0: if (ld) begin
        o_vld   = 1'b1;
        o_data  = {port_src_q, port_dst_q};
        o_keep  = 4'hF;
        state_n = HDR1;
      end
      HDR1: if (ld) begin
        o_vld   = 1'b1;
        o_data  = {ip_payload_len_o, csum_q};
        o_keep  = 4'hF;
        state_n = DATA;
      end
      DATA: if (ld && user.tvld) begin
        o_vld  = 1'b1;
        o_data = user.tdata;
        o_keep = user.tkeep;
        o_last = user.tlast;
        if (user.tlast) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state            <= IDLE;
      port_src_q       <= '0;
      port_dst_q       <= '0;
      data_csum_q      <= '0;
      csum_q           <= '0;
      hdr_ip_dest_o    <= '0;
      hdr_ip_src_o     <= '0;
      ip_payload_len_o <= '0;
      udp.tdata        <= '0;
      udp.tvld         <= 1'b0;
      udp.tlast        <= 1'b0;
      udp.tkeep        <= '0;
    end else begin
      state <= state_n;
      // Header fields are captured once per packet, on IDLE exit only.
      if (state == IDLE && user.tvld) begin
        port_src_q       <= hdr_port_src_i;
        port_dst_q       <= hdr_port_dest_i;
        data_csum_q      <= user_data_csum_i;
        hdr_ip_dest_o    <= hdr_ip_dest_i;
        hdr_ip_src_o     <= hdr_ip_src_i;
        ip_payload_len_o <= user_data_len_i + 16'd8;
      end
      if (state == CSUM) csum_q <= csum_calc;
      if (o_we) begin
        udp.tdata <= o_data;
        udp.tvld  <= o_vld;
        udp.tlast <= o_last;
        udp.tkeep <= o_keep;
      end
    end
  end

endmodule

// File: tb/tb_umstr_udp_hdr_insert.sv
// tb_umstr_udp_hdr_insert
//   Directed bench for umstr_udp_hdr_insert. A second instance with
//   CSUM_EN = 0 sees identical stimulus; its header word1 is checked
//   for a zero checksum field.
module tb_umstr_udp_hdr_insert;

  typedef struct {
    logic [31:0] ip_src;
    logic [31:0] ip_dst;
    logic [15:0] port_src;
    logic [15:0] port_dst;
    logic [15:0] len;
    logic [15:0] csum_in;
    int          nbeats;
    logic [31:0] first_data;
    logic [3:0]  last_keep;
    int          rdy_mode;   // 0 = always ready, 1 = toggling 1010...
    int          bubble_at;  // beat index followed by a 3-cycle gap, -1 none
    logic [31:0] exp_word1;  // hand-computed {udp_len, checksum}
  } vec_t;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic reset_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // ---------------- DUT signals ----------------
  logic [31:0] hdr_ip_dest, hdr_ip_src;
  logic [15:0] hdr_port_dest, hdr_port_src, data_csum, data_len;
  logic [31:0] hdr_ip_dest_o, hdr_ip_src_o, hdr_ip_dest_o2, hdr_ip_src_o2;
  logic [15:0] ip_payload_len_o, ip_payload_len_o2;
  logic [2:0]  dbg_state, dbg_state2;

  umstr_udp_hdr_insert_if u_if ();
  umstr_udp_hdr_insert_if d_if ();
  umstr_udp_hdr_insert_if u2_if ();
  umstr_udp_hdr_insert_if d2_if ();

  assign u2_if.tdata = u_if.tdata;
  assign u2_if.tvld  = u_if.tvld;
  assign u2_if.tlast = u_if.tlast;
  assign u2_if.tkeep = u_if.tkeep;
  assign d2_if.trdy  = d_if.trdy;

  umstr_udp_hdr_insert #(.CSUM_EN(1'b1)) dut (
    .clk(clk), .reset_n(reset_n),
    .hdr_ip_dest_i(hdr_ip_dest), .hdr_ip_src_i(hdr_ip_src),
    .hdr_port_dest_i(hdr_port_dest), .hdr_port_src_i(hdr_port_src),
    .user_data_csum_i(data_csum), .user_data_len_i(data_len),
    .user(u_if),
    .hdr_ip_dest_o(hdr_ip_dest_o), .hdr_ip_src_o(hdr_ip_src_o),
    .ip_payload_len_o(ip_payload_len_o),
    .udp(d_if), .dbg_state(dbg_state)
  );

  umstr_udp_hdr_insert #(.CSUM_EN(1'b0)) dut_nocsum (
    .clk(clk), .reset_n(reset_n),
    .hdr_ip_dest_i(hdr_ip_dest), .hdr_ip_src_i(hdr_ip_src),
    .hdr_port_dest_i(hdr_port_dest), .hdr_port_src_i(hdr_port_src),
    .user_data_csum_i(data_csum), .user_data_len_i(data_len),
    .user(u2_if),
    .hdr_ip_dest_o(hdr_ip_dest_o2), .hdr_ip_src_o(hdr_ip_src_o2),
    .ip_payload_len_o(ip_payload_len_o2),
    .udp(d2_if), .dbg_state(dbg_state2)
  );

  // ---------------- scoreboard state ----------------
  int n_checks = 0;
  int n_err    = 0;
  logic [36:0] exp_q[$];
  logic [36:0] got_q[$];
  int          got_cyc_q[$];
  logic [31:0] w1_exp2[$];
  logic [31:0] w1_q2[$];
  int          rdy_mode = 0;
  vec_t        vec[6];

  bit b2b_watch = 0;
  bit a_done    = 0;
  int b2b_start = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  // ---------------- output ready driver ----------------
  initial begin
    d_if.trdy = 1'b1;
    forever begin
      @(posedge clk); #1;
      if (rdy_mode == 1) d_if.trdy = !d_if.trdy;
      else d_if.trdy = 1'b1;
    end
  end

  // ---------------- monitors ----------------
  logic        stalled_prev = 1'b0;
  logic [36:0] beat_prev    = '0;
  int          idx2         = 0;

  always @(negedge clk) begin
    if (reset_n) begin
      if (d_if.tvld && d_if.trdy) begin
        got_q.push_back({d_if.tlast, d_if.tkeep, d_if.tdata});
        got_cyc_q.push_back(cyc);
      end
      if (stalled_prev)
        chk("stall_hold", {d_if.tvld, d_if.tlast, d_if.tkeep, d_if.tdata}, {1'b1, beat_prev});
      if (d_if.tvld && !d_if.trdy)
        chk("user_trdy_low_when_stalled", u_if.trdy, 0);
      stalled_prev = d_if.tvld && !d_if.trdy;
      beat_prev    = {d_if.tlast, d_if.tkeep, d_if.tdata};
      if (d2_if.tvld && d2_if.trdy) begin
        if (idx2 == 1) w1_q2.push_back(d2_if.tdata);
        idx2 = d2_if.tlast ? 0 : idx2 + 1;
      end
      if (b2b_watch && !a_done && cyc > b2b_start) begin
        chk("b2b_hdr_src_hold", hdr_ip_src_o, vec[4].ip_src);
        chk("b2b_hdr_dst_hold", hdr_ip_dest_o, vec[4].ip_dst);
      end
    end else begin
      stalled_prev = 1'b0;
      idx2 = 0;
    end
  end

  // ---------------- driver tasks ----------------
  task automatic send_beat(input logic [31:0] d, input logic [3:0] k, input logic l,
                           output int acc_cyc);
    bit acc = 0;
    int n = 0;
    u_if.tdata = d;
    u_if.tkeep = k;
    u_if.tlast = l;
    u_if.tvld  = 1'b1;
    while (!acc && n < 200) begin
      @(negedge clk);
      acc = u_if.trdy;
      @(posedge clk); #1;
      n++;
    end
    chk("beat_accept", acc, 1);
    acc_cyc = cyc;
  endtask

  task automatic send_pkt(input vec_t v, output int last_cyc);
    int c = 0;
    hdr_ip_src    = v.ip_src;
    hdr_ip_dest   = v.ip_dst;
    hdr_port_src  = v.port_src;
    hdr_port_dest = v.port_dst;
    data_len      = v.len;
    data_csum     = v.csum_in;
    for (int b = 0; b < v.nbeats; b++) begin
      send_beat(v.first_data + b * 32'h01010101,
                (b == v.nbeats - 1) ? v.last_keep : 4'hF,
                (b == v.nbeats - 1), c);
      if (b == v.bubble_at) begin
        u_if.tvld = 1'b0;
        for (int g = 0; g < 3; g++) begin
          @(posedge clk); #1;
          chk($sformatf("bubble_tvld_low%0d", g), d_if.tvld, 0);
        end
      end
    end
    u_if.tvld  = 1'b0;
    u_if.tlast = 1'b0;
    last_cyc   = c;
  endtask

  task automatic expect_pkt(input vec_t v);
    logic [15:0] ul;
    ul = v.len + 16'd8;
    exp_q.push_back({1'b0, 4'hF, v.port_src, v.port_dst});
    exp_q.push_back({1'b0, 4'hF, v.exp_word1});
    for (int b = 0; b < v.nbeats; b++)
      exp_q.push_back({(b == v.nbeats - 1),
                       (b == v.nbeats - 1) ? v.last_keep : 4'hF,
                       v.first_data + b * 32'h01010101});
    w1_exp2.push_back({ul, 16'h0000});
  endtask

  task automatic wait_out();
    int n = 0;
    while (got_q.size() < exp_q.size() && n < 300) begin
      @(posedge clk); #1;
      n++;
    end
    repeat (4) begin @(posedge clk); #1; end
  endtask

  task automatic cmp_out(input string tag);
    int k = 0;
    chk({tag, " beat_count"}, got_q.size(), exp_q.size());
    while (exp_q.size() > 0 && got_q.size() > 0) begin
      chk($sformatf("%s beat%0d", tag, k), got_q.pop_front(), exp_q.pop_front());
      k++;
    end
    exp_q.delete();
    got_q.delete();
    got_cyc_q.delete();
    chk({tag, " nocsum_word1_count"}, w1_q2.size(), w1_exp2.size());
    while (w1_exp2.size() > 0 && w1_q2.size() > 0)
      chk({tag, " nocsum_word1"}, w1_q2.pop_front(), w1_exp2.pop_front());
    w1_exp2.delete();
    w1_q2.delete();
  endtask

  // ---------------- watchdog ----------------
  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog");
  end

  // ---------------- test sequence ----------------
  initial begin
    int c;
    int a_cyc;

    //            ip_src        ip_dst        psrc     pdst     len      csum_in  n  first_data    keep  rdy bub  word1
    vec[0] = '{32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'h0004, 16'h9D9D, 1, 32'hDEADBEEF, 4'hF, 0, -1, 32'h000C7838};
    vec[1] = '{32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'h0004, 16'h15D6, 1, 32'hDEADBEEF, 4'hF, 0, -1, 32'h000CFFFF};
    vec[2] = '{32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'h0012, 16'h0000, 5, 32'h01020304, 4'hC, 1, -1, 32'h001A15BA};
    vec[3] = '{32'hC0A80001, 32'hC0A80002, 16'h1234, 16'h5678, 16'h000C, 16'h0000, 3, 32'hA0B0C0D0, 4'hF, 0,  0, 32'h001415C6};
    vec[4] = '{32'h0A000001, 32'h0A000002, 16'h0050, 16'h1F90, 16'h0008, 16'h1111, 2, 32'h11111111, 4'hF, 0, -1, 32'h0010BADA};
    vec[5] = '{32'hAC100001, 32'hAC100005, 16'h4000, 16'h8000, 16'h000C, 16'hFFFF, 3, 32'h22222222, 4'hF, 0, -1, 32'h0014E79E};

    hdr_ip_src = '0; hdr_ip_dest = '0; hdr_port_src = '0; hdr_port_dest = '0;
    data_len = '0; data_csum = '0;
    u_if.tdata = '0; u_if.tkeep = '0; u_if.tlast = 1'b0; u_if.tvld = 1'b0;
    reset_n = 1'b1;
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;

    // Reset state
    chk("rst_udp_tvld",  d_if.tvld, 0);
    chk("rst_udp_tdata", d_if.tdata, 0);
    chk("rst_udp_tkeep", d_if.tkeep, 0);
    chk("rst_udp_tlast", d_if.tlast, 0);
    chk("rst_user_trdy", u_if.trdy, 0);
    chk("rst_ip_src",    hdr_ip_src_o, 0);
    chk("rst_ip_dst",    hdr_ip_dest_o, 0);
    chk("rst_len",       ip_payload_len_o, 0);
    chk("rst_state",     dbg_state, 0);

    reset_n = 1'b1;
    @(posedge clk); #1;

    // Nominal packet with first-word latency: E1 detect, E2 checksum, E3 word0
    expect_pkt(vec[0]);
    fork
      send_pkt(vec[0], c);
      begin
        @(posedge clk); #2;
        chk("lat_e1_tvld", d_if.tvld, 0);
        chk("lat_e1_len", ip_payload_len_o, 16'h000C);
        chk("lat_e1_ip_src", hdr_ip_src_o, 32'hC0A80001);
        chk("lat_e1_ip_dst", hdr_ip_dest_o, 32'hC0A80002);
        @(posedge clk); #2;
        chk("lat_e2_tvld", d_if.tvld, 0);
        @(posedge clk); #2;
        chk("lat_e3_tvld", d_if.tvld, 1);
        chk("lat_e3_word0", d_if.tdata, 32'h12345678);
      end
    join
    wait_out();
    cmp_out("nominal");

    // Table: nominal, zero-checksum substitution, backpressure, input bubble
    for (int i = 0; i < 4; i++) begin
      rdy_mode = vec[i].rdy_mode;
      expect_pkt(vec[i]);
      send_pkt(vec[i], c);
      wait_out();
      rdy_mode = 0;
      cmp_out($sformatf("vec%0d", i));
      chk($sformatf("vec%0d len_o", i), ip_payload_len_o, vec[i].len + 16'd8);
      chk($sformatf("vec%0d ip_src_o", i), hdr_ip_src_o, vec[i].ip_src);
    end

    // Back-to-back packets with no input gap
    expect_pkt(vec[4]);
    expect_pkt(vec[5]);
    a_done    = 0;
    b2b_start = cyc;
    b2b_watch = 1;
    send_pkt(vec[4], a_cyc);
    a_done = 1;
    chk("b2b_hdr_src_at_tlast", hdr_ip_src_o, vec[4].ip_src);
    send_pkt(vec[5], c);
    b2b_watch = 0;
    chk("b2b_hdr_src_b", hdr_ip_src_o, vec[5].ip_src);
    chk("b2b_hdr_dst_b", hdr_ip_dest_o, vec[5].ip_dst);
    chk("b2b_len_b", ip_payload_len_o, 16'h0014);
    wait_out();
    chk("b2b_word0_count", got_cyc_q.size() > 4, 1);
    if (got_cyc_q.size() > 4) chk("b2b_word0_cycle", got_cyc_q[4], a_cyc + 3);
    cmp_out("b2b");

    // Reset during DATA of a 4-beat packet
    hdr_ip_src = vec[2].ip_src; hdr_ip_dest = vec[2].ip_dst;
    hdr_port_src = 16'hAAAA; hdr_port_dest = 16'hBBBB;
    data_len = 16'h0010; data_csum = 16'h0000;
    send_beat(32'h55555555, 4'hF, 1'b0, c);
    send_beat(32'h66666666, 4'hF, 1'b0, c);
    reset_n   = 1'b0;
    u_if.tvld = 1'b0;
    #1;
    chk("midrst_udp_tvld",  d_if.tvld, 0);
    chk("midrst_udp_tdata", d_if.tdata, 0);
    chk("midrst_udp_tlast", d_if.tlast, 0);
    chk("midrst_udp_tkeep", d_if.tkeep, 0);
    chk("midrst_user_trdy", u_if.trdy, 0);
    chk("midrst_ip_src",    hdr_ip_src_o, 0);
    chk("midrst_len",       ip_payload_len_o, 0);
    chk("midrst_state",     dbg_state, 0);
    chk("midrst_nocsum_tvld", d2_if.tvld, 0);
    @(posedge clk); #1;
    reset_n = 1'b1;
    exp_q.delete(); got_q.delete(); got_cyc_q.delete(); w1_exp2.delete(); w1_q2.delete();
    @(posedge clk); #1;

    expect_pkt(vec[0]);
    send_pkt(vec[0], c);
    wait_out();
    cmp_out("after_reset");
    chk("after_reset_len", ip_payload_len_o, 16'h000C);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_err);
    $finish;
  end

endmodule
